// File: rtl/hawkes_thinning_stage.sv
`default_nettype none
// ============================================================================
// Module   : hawkes_thinning_stage
// Purpose  : Discrete-time Ogata thinning of one Hawkes path. Each accepted
//            uniform sample u is compared against the top DATA_W bits of the
//            current intensity lam = sat(mu + exc). A hit emits an event,
//            bumps the event count and adds alpha to the decaying excitation.
//            One path of n_steps accepted samples is run per start pulse.
// Ports    : clk, rst_n (sync, active-low)
//            start, mu, alpha, n_steps  - path launch and its parameters
//            rnd_in, rnd_valid, rnd_ready - uniform sample handshake
//            evt, evt_count, busy, done - path status and result
//            last_evt_step, lam_out     - trace outputs (HAWKES_TRACE_EN only)
// Config   : define HAWKES_TRACE_EN to add the trace outputs.
// Revision : 1.0 - initial release
// ============================================================================
module hawkes_thinning_stage #(
    parameter int DATA_W      = 8,
    parameter int INT_W       = 16,
    parameter int CNT_W       = 16,
    parameter int STEP_W      = 16,
    parameter int DECAY_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [INT_W-1:0]  mu,
    input  logic [INT_W-1:0]  alpha,
    input  logic [STEP_W-1:0] n_steps,
    input  logic [DATA_W-1:0] rnd_in,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    output logic              evt,
    output logic [CNT_W-1:0]  evt_count,
    output logic              busy,
    output logic              done
`ifdef HAWKES_TRACE_EN
    ,
    output logic [STEP_W-1:0] last_evt_step,
    output logic [INT_W-1:0]  lam_out
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [INT_W-1:0]    mu_q;
    logic [INT_W-1:0]    alpha_q;
    logic [STEP_W-1:0]   n_steps_q;
    logic [INT_W-1:0]    exc_q;
    logic [INT_W-1:0]    exc_d;
    logic [STEP_W-1:0]   step_cnt_q;
    logic [CNT_W-1:0]    evt_count_q;
    logic [CNT_W-1:0]    evt_count_d;
    logic                evt_q;
    logic                done_q;
    logic                busy_q;
    logic                rnd_ready_q;
`ifdef HAWKES_TRACE_EN
    logic [STEP_W-1:0]   last_evt_step_q;
    logic [INT_W-1:0]    lam_out_q;
`endif

    // Datapath for the current step
    logic [INT_W:0]      w_lam_sum;
    logic [INT_W-1:0]    w_lam;
    logic [DATA_W-1:0]   w_thr;
    logic                w_hit;
    logic [INT_W-1:0]    w_exc_decay;
    logic [INT_W-1:0]    w_alpha_add;
    logic [INT_W:0]      w_exc_sum;
    logic                w_accept;
    logic                w_last_step;

    always_comb begin
        // Intensity saturates rather than wrapping so a huge excitation
        // still reads as "certain event" instead of a small threshold.
        w_lam_sum   = {1'b0, mu_q} + {1'b0, exc_q};
        w_lam       = w_lam_sum[INT_W] ? {INT_W{1'b1}} : w_lam_sum[INT_W-1:0];
        w_thr       = w_lam[INT_W-1 -: DATA_W];
        // Strict compare: u = max never hits, thr = 0 never hits.
        w_hit       = (rnd_in < w_thr);

        // Decay can never underflow since exc >> k <= exc.
        w_exc_decay = exc_q - (exc_q >> DECAY_SHIFT);
        w_alpha_add = w_hit ? alpha_q : {INT_W{1'b0}};
        w_exc_sum   = {1'b0, w_exc_decay} + {1'b0, w_alpha_add};
        exc_d       = w_exc_sum[INT_W] ? {INT_W{1'b1}} : w_exc_sum[INT_W-1:0];

        evt_count_d = evt_count_q;
        if (w_hit && (evt_count_q != {CNT_W{1'b1}})) begin
            evt_count_d = evt_count_q + CNT_W'(1);
        end

        w_accept    = rnd_valid & rnd_ready_q;
        // n_steps_q is non-zero whenever RUN is active, so no underflow here.
        w_last_step = (step_cnt_q == (n_steps_q - STEP_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            mu_q            <= '0;
            alpha_q         <= '0;
            n_steps_q       <= '0;
            exc_q           <= '0;
            step_cnt_q      <= '0;
            evt_count_q     <= '0;
            evt_q           <= 1'b0;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
            rnd_ready_q     <= 1'b0;
`ifdef HAWKES_TRACE_EN
            last_evt_step_q <= '0;
            lam_out_q       <= '0;
`endif
        end else begin
            evt_q  <= 1'b0;
            done_q <= 1'b0;
`ifdef HAWKES_TRACE_EN
            lam_out_q <= w_lam;
`endif
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mu_q        <= mu;
                        alpha_q     <= alpha;
                        n_steps_q   <= n_steps;
                        exc_q       <= '0;
                        step_cnt_q  <= '0;
                        evt_count_q <= '0;
`ifdef HAWKES_TRACE_EN
                        last_evt_step_q <= '0;
`endif
                        if (n_steps != '0) begin
                            state_q     <= S_RUN;
                            busy_q      <= 1'b1;
                            rnd_ready_q <= 1'b1;
                        end else begin
                            // Empty path: report completion straight away.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Without an accept everything is frozen, including decay.
                    if (w_accept) begin
                        exc_q       <= exc_d;
                        evt_count_q <= evt_count_d;
                        step_cnt_q  <= step_cnt_q + STEP_W'(1);
                        evt_q       <= w_hit;
`ifdef HAWKES_TRACE_EN
                        if (w_hit) begin
                            last_evt_step_q <= step_cnt_q;
                        end
`endif
                        if (w_last_step) begin
                            // Drop ready on the same edge so no extra sample
                            // is consumed beyond n_steps.
                            state_q     <= S_DONE;
                            busy_q      <= 1'b0;
                            rnd_ready_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    rnd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign rnd_ready = rnd_ready_q;
    assign evt       = evt_q;
    assign evt_count = evt_count_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef HAWKES_TRACE_EN
    assign last_evt_step = last_evt_step_q;
    assign lam_out       = lam_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hawkes_thinning_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_hawkes_thinning_stage
// Purpose  : Self-checking bench for hawkes_thinning_stage. A behavioural
//            model predicts the registered outputs for every driven cycle;
//            predictions are queued and compared after the clock edge.
// Config   : define HAWKES_TRACE_EN to also check last_evt_step / lam_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hawkes_thinning_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] mu;
    logic [15:0] alpha;
    logic [15:0] n_steps;
    logic [7:0]  rnd_in;
    logic        rnd_valid;
    logic        rnd_ready;
    logic        evt;
    logic [15:0] evt_count;
    logic        busy;
    logic        done;
`ifdef HAWKES_TRACE_EN
    logic [15:0] last_evt_step;
    logic [15:0] lam_out;
`endif

    always #5 clk = ~clk;

    hawkes_thinning_stage #(
        .DATA_W      (8),
        .INT_W       (16),
        .CNT_W       (16),
        .STEP_W      (16),
        .DECAY_SHIFT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mu        (mu),
        .alpha     (alpha),
        .n_steps   (n_steps),
        .rnd_in    (rnd_in),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .evt       (evt),
        .evt_count (evt_count),
        .busy      (busy),
        .done      (done)
`ifdef HAWKES_TRACE_EN
        ,
        .last_evt_step (last_evt_step),
        .lam_out       (lam_out)
`endif
    );

    typedef struct packed {
        logic        evt;
        logic [15:0] cnt;
        logic        busy;
        logic        done;
        logic        rdy;
        logic [15:0] last_step;
        logic [15:0] lam;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (0 = idle, 1 = run, 2 = done)
    int          m_state;
    logic [15:0] m_mu, m_alpha, m_n, m_exc, m_step, m_cnt, m_last, m_lam;
    logic        m_evt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_mu = '0; m_alpha = '0; m_n = '0;
        m_exc = '0; m_step = '0; m_cnt = '0; m_last = '0; m_lam = '0;
        m_evt = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic vld, input logic [7:0] u);
        logic [15:0] lam;
        logic        hit;
        m_lam = sat_add(m_mu, m_exc);
        m_evt = 1'b0;
        case (m_state)
            0: if (st) begin
                m_mu = mu; m_alpha = alpha; m_n = n_steps;
                m_exc = '0; m_step = '0; m_cnt = '0; m_last = '0;
                m_state = (n_steps != 16'd0) ? 1 : 2;
            end
            1: if (vld) begin
                lam = sat_add(m_mu, m_exc);
                hit = (u < lam[15:8]);
                m_exc = sat_add(m_exc - (m_exc >> 4), hit ? m_alpha : 16'd0);
                if (hit) begin
                    m_last = m_step;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
                m_evt = hit;
                if (m_step == m_n - 16'd1) m_state = 2;
                m_step = m_step + 16'd1;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check({tag, ".evt"},       evt,       e.evt);
        check({tag, ".evt_count"}, evt_count, e.cnt);
        check({tag, ".busy"},      busy,      e.busy);
        check({tag, ".done"},      done,      e.done);
        check({tag, ".rnd_ready"}, rnd_ready, e.rdy);
`ifdef HAWKES_TRACE_EN
        check({tag, ".last_evt_step"}, last_evt_step, e.last_step);
        check({tag, ".lam_out"},       lam_out,       e.lam);
`endif
    endtask

    task automatic push_expected();
        exp_t e;
        e.evt       = m_evt;
        e.cnt       = m_cnt;
        e.busy      = (m_state == 1);
        e.done      = (m_state == 2);
        e.rdy       = (m_state == 1);
        e.last_step = m_last;
        e.lam       = m_lam;
        sb_q.push_back(e);
    endtask

    // One clock: drive inputs, predict, clock, compare.
    task automatic tick(input string tag, input logic st, input logic vld, input logic [7:0] u);
        start     = st;
        rnd_valid = vld;
        rnd_in    = u;
        model_step(st, vld, u);
        push_expected();
        @(posedge clk);
        #1;
        compare_outputs(tag);
        start = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        start     = 1'b0;
        rnd_valid = 1'b0;
        model_reset();
        push_expected();
        @(posedge clk);
        #1;
        compare_outputs(tag);
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input logic [15:0] m, input logic [15:0] a, input logic [15:0] n);
        mu = m; alpha = a; n_steps = n;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rnd_valid = 1'b0; rnd_in = '0;
        mu = '0; alpha = '0; n_steps = '0;
        model_reset();
        #1;
        do_reset("reset");
        tick("idle", 1'b0, 1'b1, 8'd0);

        // Zero intensity: no events, done right after the 10th accept.
        set_cfg(16'h0000, 16'h0000, 16'd10);
        tick("t1_start", 1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 10; i++) tick("t1_run", 1'b0, 1'b1, 8'($urandom_range(0, 255)));
        tick("t1_done", 1'b0, 1'b1, 8'd0);
        tick("t1_idle", 1'b0, 1'b0, 8'd0);

        // Near-full intensity: u=0 always hits, u=255 never does.
        set_cfg(16'hFF00, 16'h0000, 16'd5);
        tick("t2a_start", 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) tick("t2a_run", 1'b0, 1'b1, 8'd0);
        tick("t2a_done", 1'b0, 1'b0, 8'd0);
        tick("t2a_hold", 1'b0, 1'b0, 8'd0);
        tick("t2b_start", 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) tick("t2b_run", 1'b0, 1'b1, 8'd255);
        tick("t2b_done", 1'b0, 1'b0, 8'd0);
        tick("t2b_idle", 1'b0, 1'b0, 8'd0);

        // Self-excitation: thresholds 16, 48, then 78 (u=78 is a strict miss).
        set_cfg(16'h1000, 16'h2000, 16'd4);
        tick("t3_start", 1'b1, 1'b0, 8'd0);
        tick("t3_s0", 1'b0, 1'b1, 8'd0);
        tick("t3_s1", 1'b0, 1'b1, 8'd20);
        tick("t3_s2", 1'b0, 1'b1, 8'd78);
        tick("t3_s3", 1'b0, 1'b1, 8'd70);
        tick("t3_done", 1'b0, 1'b0, 8'd0);
        tick("t3_idle", 1'b0, 1'b0, 8'd0);

        // Stall mid-run: state frozen while rnd_valid is low.
        set_cfg(16'h8000, 16'h0100, 16'd6);
        tick("t4_start", 1'b1, 1'b0, 8'd0);
        tick("t4_s0", 1'b0, 1'b1, 8'd10);
        tick("t4_s1", 1'b0, 1'b1, 8'd200);
        for (int i = 0; i < 3; i++) tick("t4_stall", 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) tick("t4_resume", 1'b0, 1'b1, 8'(8'd120 + 8'(i)));
        tick("t4_done", 1'b0, 1'b0, 8'd0);
        tick("t4_idle", 1'b0, 1'b0, 8'd0);

        // Excitation saturation, start ignored while running, empty path.
        set_cfg(16'hFF00, 16'hFFFF, 16'd6);
        tick("t5_start", 1'b1, 1'b0, 8'd0);
        tick("t5_s0", 1'b0, 1'b1, 8'd0);
        tick("t5_s1", 1'b0, 1'b1, 8'd0);
        set_cfg(16'h0000, 16'h0000, 16'd2);
        tick("t5_restart", 1'b1, 1'b1, 8'd0);
        tick("t5_s3", 1'b0, 1'b1, 8'd254);
        tick("t5_s4", 1'b0, 1'b1, 8'd254);
        tick("t5_s5", 1'b0, 1'b1, 8'd254);
        tick("t5_done", 1'b1, 1'b1, 8'd0);
        tick("t5_idle", 1'b0, 1'b0, 8'd0);
        set_cfg(16'h4000, 16'h0000, 16'd0);
        tick("t5_zero_start", 1'b1, 1'b1, 8'd0);
        tick("t5_zero_idle", 1'b0, 1'b1, 8'd0);
        tick("t5_zero_hold", 1'b0, 1'b0, 8'd0);

        // Reset mid-run abandons the path with no done pulse.
        set_cfg(16'h8000, 16'h0400, 16'd8);
        tick("t6_start", 1'b1, 1'b0, 8'd0);
        tick("t6_s0", 1'b0, 1'b1, 8'd5);
        tick("t6_s1", 1'b0, 1'b1, 8'd90);
        tick("t6_s2", 1'b0, 1'b1, 8'd3);
        do_reset("t6_reset");
        for (int i = 0; i < 3; i++) tick("t6_after", 1'b0, 1'b1, 8'd0);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
